// File: rtl/bcd_scan_display_if.sv
// Conversion handshake between a value source and bcd_scan_display:
// source drives bin_in/load, converter returns busy/done/bcd_out.
interface bcd_scan_display_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) ();
   logic [BIN_W-1:0]    bin_in;
   logic                load;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] bcd_out;

   modport master (output bin_in, load, input busy, done, bcd_out);
   modport slave  (input bin_in, load, output busy, done, bcd_out);
endinterface

// File: rtl/bcd_scan_display.sv
// Binary-to-BCD double-dabble converter (BIN_W cycles busy, done on the last) driving a scanned 7-seg display.
// No queueing: load is only taken while idle; the scan free-runs and latches bcd_out on each digit tick.
module bcd_scan_display #(
   parameter int BIN_W       = 8,
   parameter int DIGITS      = 3,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              rst,
   bcd_scan_display_if.slave conv,
   output logic [DIGITS-1:0] ANODE,
   output logic              A,
   output logic              B,
   output logic              C,
   output logic              D,
   output logic              E,
   output logic              F,
   output logic              G
);

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   localparam int ITER_W = $clog2(BIN_W + 1);
   localparam int RW     = $clog2(REFRESH_DIV);
   localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW     = 4 * DIGITS;

   if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
      $fatal(1, "bcd_scan_display: BIN_W must be in 1..32");
   end
   if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
      $fatal(1, "bcd_scan_display: DIGITS too small for BIN_W");
   end
   if (REFRESH_DIV < 2) begin : g_bad_refresh
      $fatal(1, "bcd_scan_display: REFRESH_DIV must be >= 2");
   end

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [BIN_W-1:0]  shift_q;
   logic [BW-1:0]     scratch_q;
   logic [ITER_W-1:0] iter_q;
   logic              busy_q;
   logic              done_q;
   logic [BW-1:0]     bcd_q;
   logic [BW-1:0]     adj;
   logic [BW-1:0]     scratch_nxt;

   // add-3 correction on every nibble, then shift in the next binary bit
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
      scratch_nxt = {adj[BW-2:0], shift_q[BIN_W-1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         iter_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (conv.load) begin
                  shift_q   <= conv.bin_in;
                  scratch_q <= '0;
                  iter_q    <= ITER_W'(BIN_W);
                  busy_q    <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               scratch_q <= scratch_nxt;
               shift_q   <= shift_q << 1;
               iter_q    <= iter_q - ITER_W'(1);
               if (iter_q == ITER_W'(1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  bcd_q  <= scratch_nxt;
               end
            end
         endcase
      end
   end

   assign conv.busy    = busy_q;
   assign conv.done    = done_q;
   assign conv.bcd_out = bcd_q;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] seg_on;  // {a,b,c,d,e,f,g}, 1 = lit
      case (d)
         4'd0:    seg_on = 7'b1111110;
         4'd1:    seg_on = 7'b0110000;
         4'd2:    seg_on = 7'b1101101;
         4'd3:    seg_on = 7'b1111001;
         4'd4:    seg_on = 7'b0110011;
         4'd5:    seg_on = 7'b1011011;
         4'd6:    seg_on = 7'b1011111;
         4'd7:    seg_on = 7'b1110000;
         4'd8:    seg_on = 7'b1111111;
         4'd9:    seg_on = 7'b1111011;
         default: seg_on = 7'b0000000;
      endcase
      return ~seg_on;
   endfunction

   logic [RW-1:0]     refresh_q;
   logic [IW-1:0]     digit_q;
   logic [DIGITS-1:0] anode_q;
   logic [6:0]        seg_q;
   logic              tick;
   logic [IW-1:0]     nxt_idx;
   logic [3:0]        nxt_nib;
   logic              nxt_lz;
   logic              nxt_blank;
   logic              nz_above;
   logic [DIGITS-1:0] anode_nxt;

   assign tick = (refresh_q == RW'(REFRESH_DIV - 1));

   // pattern for the slot that starts on the next tick; blank if this and all higher digits are zero
   always_comb begin
      nxt_idx  = (digit_q == IW'(DIGITS - 1)) ? '0 : digit_q + IW'(1);
      nxt_nib  = '0;
      nxt_lz   = 1'b0;
      nz_above = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nz_above = nz_above | (bcd_q[4*i +: 4] != 4'd0);
         if (nxt_idx == IW'(i)) begin
            nxt_nib = bcd_q[4*i +: 4];
            nxt_lz  = !nz_above;
         end
      end
      nxt_blank = (BLANK_LZ != 0) && (nxt_idx != '0) && nxt_lz;
      anode_nxt = '1;
      for (int i = 0; i < DIGITS; i++) begin
         anode_nxt[i] = nxt_blank || (nxt_idx != IW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_q <= '0;
         digit_q   <= IW'(DIGITS - 1);
         anode_q   <= '1;
         seg_q     <= '1;
      end else if (tick) begin
         refresh_q <= '0;
         digit_q   <= nxt_idx;
         anode_q   <= anode_nxt;
         seg_q     <= nxt_blank ? 7'h7F : seg_decode(nxt_nib);
      end else begin
         refresh_q <= refresh_q + RW'(1);
      end
   end

   assign ANODE = anode_q;
   assign {A, B, C, D, E, F, G} = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: three instances (8-bit no blanking, 8-bit blanking, 12-bit).
module tb_bcd_scan_display;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   bcd_scan_display_if #(.BIN_W(8),  .DIGITS(3)) if_a ();
   bcd_scan_display_if #(.BIN_W(8),  .DIGITS(3)) if_b ();
   bcd_scan_display_if #(.BIN_W(12), .DIGITS(4)) if_c ();

   logic [2:0] an_a, an_b;
   logic [3:0] an_c;
   logic [6:0] seg_a, seg_b, seg_c;

   bcd_scan_display #(.BIN_W(8), .DIGITS(3), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_a (
      .clk(clk), .rst(rst), .conv(if_a), .ANODE(an_a),
      .A(seg_a[6]), .B(seg_a[5]), .C(seg_a[4]), .D(seg_a[3]), .E(seg_a[2]), .F(seg_a[1]), .G(seg_a[0]));

   bcd_scan_display #(.BIN_W(8), .DIGITS(3), .REFRESH_DIV(4), .BLANK_LZ(1)) dut_b (
      .clk(clk), .rst(rst), .conv(if_b), .ANODE(an_b),
      .A(seg_b[6]), .B(seg_b[5]), .C(seg_b[4]), .D(seg_b[3]), .E(seg_b[2]), .F(seg_b[1]), .G(seg_b[0]));

   bcd_scan_display #(.BIN_W(12), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut_c (
      .clk(clk), .rst(rst), .conv(if_c), .ANODE(an_c),
      .A(seg_c[6]), .B(seg_c[5]), .C(seg_c[4]), .D(seg_c[3]), .E(seg_c[2]), .F(seg_c[1]), .G(seg_c[0]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [31:0] v);
      if_a.load   = ld;
      if_b.load   = ld;
      if_c.load   = ld;
      if_a.bin_in = v[7:0];
      if_b.bin_in = v[7:0];
      if_c.bin_in = v[11:0];
   endtask

   function automatic logic [2:0] get_an(input int w);
      return (w == 0) ? an_a : an_b;
   endfunction

   function automatic logic [6:0] get_seg(input int w);
      return (w == 0) ? seg_a : seg_b;
   endfunction

   // one load on all instances; optional extra load pulse while busy must be ignored
   task automatic run_conv(input string tag, input logic [31:0] v, input logic [11:0] exp_a,
                           input logic [15:0] exp_c, input int repulse);
      int busy_a, busy_c, done_a, done_c, at_a, at_c;
      busy_a = 0; busy_c = 0; done_a = 0; done_c = 0; at_a = -1; at_c = -1;
      @(posedge clk); #1; drive(1'b1, v);
      @(posedge clk); #1; drive(1'b0, ~v);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == repulse) drive(1'b1, 32'd0);
         else if (k == repulse + 1) drive(1'b0, 32'd0);
         busy_a += int'(if_a.busy);
         busy_c += int'(if_c.busy);
         if (if_a.done) begin done_a++; if (at_a < 0) at_a = k; end
         if (if_c.done) begin done_c++; if (at_c < 0) at_c = k; end
      end
      check($sformatf("%s busy_a", tag), 32'(busy_a), 32'd8);
      check($sformatf("%s done_a", tag), 32'(done_a), 32'd1);
      check($sformatf("%s done_a_at", tag), 32'(at_a), 32'd8);
      check($sformatf("%s bcd_a", tag), 32'(if_a.bcd_out), 32'(exp_a));
      check($sformatf("%s bcd_b", tag), 32'(if_b.bcd_out), 32'(exp_a));
      check($sformatf("%s busy_c", tag), 32'(busy_c), 32'd12);
      check($sformatf("%s done_c", tag), 32'(done_c), 32'd1);
      check($sformatf("%s done_c_at", tag), 32'(at_c), 32'd12);
      check($sformatf("%s bcd_c", tag), 32'(if_c.bcd_out), 32'(exp_c));
   endtask

   // slot s expectations packed as an_exp[3*s +: 3], sg_exp[7*s +: 7] ({A..G}); slot 0 is digit 0
   task automatic scan_check(input string tag, input int w, input logic [8:0] an_exp, input logic [20:0] sg_exp);
      logic [2:0] prev, cur;
      logic [2:0] an0;
      bit found;
      int good;
      found = 1'b0;
      an0 = an_exp[2:0];
      prev = get_an(w);
      for (int k = 0; k < 24 && !found; k++) begin
         @(negedge clk);
         cur = get_an(w);
         if (cur == an0 && prev != cur) found = 1'b1;
         prev = cur;
      end
      check($sformatf("%s sync", tag), 32'(found), 32'd1);
      if (found) begin
         for (int s = 0; s < 6; s++) begin
            good = 0;
            for (int c = 0; c < 4; c++) begin
               if (get_an(w) == an_exp[3*(s%3) +: 3] && get_seg(w) == sg_exp[7*(s%3) +: 7]) good++;
               @(negedge clk);
            end
            check($sformatf("%s slot%0d", tag, s), 32'(good), 32'd4);
         end
      end
   endtask

   initial begin
      int cnt, second;

      drive(1'b1, 32'h5A);
      repeat (3) @(negedge clk);
      check("rst busy", 32'(if_a.busy), 32'd0);
      check("rst done", 32'(if_a.done), 32'd0);
      check("rst bcd", 32'(if_a.bcd_out), 32'd0);
      check("rst anode", 32'(an_a), 32'h7);
      check("rst seg", 32'(seg_a), 32'h7F);
      check("rst anode_c", 32'(an_c), 32'hF);

      @(posedge clk); #1; rst = 1'b1; drive(1'b0, 32'd0);
      repeat (4) @(negedge clk);
      check("pre-tick busy", 32'(if_a.busy), 32'd0);
      check("pre-tick anode", 32'(an_a), 32'h7);
      check("pre-tick seg", 32'(seg_a), 32'h7F);
      @(negedge clk);
      check("first tick anode", 32'(an_a), 32'h6);
      check("first tick seg", 32'(seg_a), 32'h01);

      run_conv("v255", 32'd255, 12'h255, 16'h0255, -1);
      scan_check("a255", 0, {3'b011, 3'b101, 3'b110}, {7'b0010010, 7'b0100100, 7'b0100100});

      run_conv("v0", 32'd0, 12'h000, 16'h0000, -1);
      scan_check("b0", 1, {3'b111, 3'b111, 3'b110}, {7'h7F, 7'h7F, 7'b0000001});

      run_conv("v100", 32'd100, 12'h100, 16'h0100, -1);
      run_conv("v37ign", 32'd37, 12'h037, 16'h0037, 3);

      run_conv("v7", 32'd7, 12'h007, 16'h0007, -1);
      scan_check("a7", 0, {3'b011, 3'b101, 3'b110}, {7'b0000001, 7'b0000001, 7'b0001111});
      scan_check("b7", 1, {3'b111, 3'b111, 3'b110}, {7'h7F, 7'h7F, 7'b0001111});

      // load held high: accepted again one cycle after each done
      cnt = 0; second = -1;
      @(posedge clk); #1; drive(1'b1, 32'd200);
      @(posedge clk); #1;
      for (int k = 0; k < 27; k++) begin
         @(negedge clk);
         if (if_a.done) begin cnt++; if (cnt == 2) second = k; end
         if (k == 26) drive(1'b0, 32'd200);
      end
      check("b2b done count", 32'(cnt), 32'd3);
      check("b2b second done", 32'(second), 32'd17);
      check("b2b bcd", 32'(if_a.bcd_out), 32'h200);
      repeat (16) @(posedge clk);

      run_conv("v4095", 32'd4095, 12'h255, 16'h4095, -1);

      // reset in the middle of a conversion
      @(posedge clk); #1; drive(1'b1, 32'd999);
      @(posedge clk); #1; drive(1'b0, 32'd999);
      repeat (7) @(negedge clk);
      check("mid busy_c", 32'(if_c.busy), 32'd1);
      rst = 1'b0;
      #1;
      check("abort busy_c", 32'(if_c.busy), 32'd0);
      check("abort done_c", 32'(if_c.done), 32'd0);
      check("abort bcd_c", 32'(if_c.bcd_out), 32'd0);
      check("abort anode_c", 32'(an_c), 32'hF);
      check("abort seg_c", 32'(seg_c), 32'h7F);
      repeat (2) @(posedge clk);
      #1; rst = 1'b1;
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         cnt += int'(if_c.done) + int'(if_a.done);
      end
      check("abort no done", 32'(cnt), 32'd0);
      check("abort bcd_c after", 32'(if_c.bcd_out), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
